// File: rtl/fu_cfg_loader.sv
// Config loader for the function-cell array: streams addressed words into a
// shadow bank and commits the whole bank to the active outputs atomically.
module fu_cfg_loader #(
    parameter int NUM_FU = 16,
    parameter int CFG_W  = 4,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [CFG_W-1:0]         cfg_data,
    input  logic                     cfg_last,
    output logic [NUM_FU*CFG_W-1:0]  config_sig_bus,
    output logic                     commit_done,
    output logic                     err_addr,
    output logic [CNT_W-1:0]         word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic                       r_ready;
    logic                       r_done;
    logic                       r_err;
    logic [CNT_W-1:0]           r_count;
    logic [CFG_W-1:0]           r_shadow [NUM_FU];
    logic [NUM_FU*CFG_W-1:0]    r_active;

    logic                       w_xfer;
    logic                       w_oor;
    logic                       w_first;
    logic                       w_err_base;
    logic [CNT_W-1:0]           w_cnt_base;
    logic [CNT_W-1:0]           w_cnt_next;

    assign w_xfer     = cfg_valid & r_ready;
    assign w_oor      = (cfg_addr >= ADDR_W'(NUM_FU));
    // A transfer seen in IDLE opens a new stream and restarts the status
    assign w_first    = (r_state == S_IDLE);
    assign w_err_base = w_first ? 1'b0 : r_err;
    assign w_cnt_base = w_first ? '0 : r_count;
    assign w_cnt_next = (&w_cnt_base) ? w_cnt_base
                                      : w_cnt_base + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
            r_active <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE, S_LOAD: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        for (int i = 0; i < NUM_FU; i++) begin
                            if (!w_oor && cfg_addr == ADDR_W'(i)) begin
                                r_shadow[i] <= cfg_data;
                            end
                        end
                        r_err   <= w_err_base | w_oor;
                        r_count <= w_cnt_next;
                        if (cfg_last) begin
                            r_state <= S_COMMIT;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_FU; i++) begin
                        r_active[i*CFG_W +: CFG_W] <= r_shadow[i];
                    end
                    r_done  <= 1'b1;
                    r_ready <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready      = r_ready;
    assign config_sig_bus = r_active;
    assign commit_done    = r_done;
    assign err_addr       = r_err;
    assign word_count     = r_count;

endmodule

// File: tb/tb_fu_cfg_loader.sv
// Bench for fu_cfg_loader: event-timed reference model checked every cycle,
// plus literal expectations for the directed streams.
module tb_fu_cfg_loader;

    localparam int NUM_FU = 16;
    localparam int CFG_W  = 4;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;
    localparam int BUS_W  = NUM_FU * CFG_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [CFG_W-1:0]  cfg_data = '0;
    logic              cfg_last = 1'b0;
    logic [BUS_W-1:0]  config_sig_bus;
    logic              commit_done;
    logic              err_addr;
    logic [CNT_W-1:0]  word_count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    fu_cfg_loader #(
        .NUM_FU(NUM_FU), .CFG_W(CFG_W),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_last(cfg_last),
        .config_sig_bus(config_sig_bus),
        .commit_done(commit_done), .err_addr(err_addr),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Reference model: banks as arrays, timing from the edge number of the
    // last accepted word (bus at +1, done during +1..+2, ready back at +2).
    int   m_shadow [NUM_FU];
    int   m_active [NUM_FU];
    int   m_edge = 0;
    int   m_last_edge = -100;
    bit   m_in_stream = 1'b0;
    bit   m_ready = 1'b0;
    bit   m_done = 1'b0;
    bit   m_err = 1'b0;
    int   m_cnt = 0;

    function automatic logic [BUS_W-1:0] m_bus();
        logic [BUS_W-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_FU; i++) b[i*CFG_W +: CFG_W] = CFG_W'(m_active[i]);
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_edge = 0;
            m_last_edge = -100;
            m_in_stream = 1'b0;
            m_ready = 1'b0;
            m_done = 1'b0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            bit xfer;
            xfer = cfg_valid && m_ready;
            m_edge++;
            if (m_edge == m_last_edge + 1)
                for (int i = 0; i < NUM_FU; i++) m_active[i] = m_shadow[i];
            if (xfer) begin
                if (!m_in_stream) begin
                    m_err = 1'b0;
                    m_cnt = 0;
                end
                m_in_stream = 1'b1;
                if (int'(cfg_addr) < NUM_FU) m_shadow[cfg_addr] = int'(cfg_data);
                else m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
                if (cfg_last) begin
                    m_last_edge = m_edge;
                    m_in_stream = 1'b0;
                end
            end
            m_done  = (m_edge == m_last_edge + 1);
            m_ready = (m_edge - m_last_edge >= 2);
        end
    end

    task automatic chk(input string nm, input logic [BUS_W-1:0] act,
                       input logic [BUS_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_bus", config_sig_bus, m_bus());
            chk("m_ready", BUS_W'(cfg_ready), BUS_W'(m_ready));
            chk("m_done", BUS_W'(commit_done), BUS_W'(m_done));
            chk("m_err", BUS_W'(err_addr), BUS_W'(m_err));
            chk("m_cnt", BUS_W'(word_count), BUS_W'(m_cnt));
        end
    end

    // Present a word and return 1 time unit after the edge that accepts it
    task automatic send(input int a, input int d, input bit l);
        int t;
        cfg_valid = 1'b1;
        cfg_addr  = ADDR_W'(a);
        cfg_data  = CFG_W'(d);
        cfg_last  = l;
        t = 0;
        forever begin
            @(negedge clk);
            if (cfg_ready === 1'b1) begin
                @(posedge clk);
                #1;
                break;
            end
            t++;
            if (t > 50) begin
                n_err++;
                $display("FAIL send_timeout: ready stuck at %b", cfg_ready);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

    initial begin
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        chk("idle_bus", config_sig_bus, '0);
        chk("idle_ready", BUS_W'(cfg_ready), BUS_W'(1));

        // Stream A with valid held high throughout
        send(0, 2, 0);
        send(3, 5, 0);
        chk("load_bus", config_sig_bus, '0);
        send(15, 9, 1);
        cfg_valid = 1'b0;
        chk("a_bus_n", config_sig_bus, '0);
        chk("a_rdy_n", BUS_W'(cfg_ready), BUS_W'(0));
        step();
        chk("a_bus_n1", config_sig_bus, 64'h9000_0000_0000_5002);
        chk("a_done_n1", BUS_W'(commit_done), BUS_W'(1));
        chk("a_rdy_n1", BUS_W'(cfg_ready), BUS_W'(0));
        step();
        chk("a_done_n2", BUS_W'(commit_done), BUS_W'(0));
        chk("a_rdy_n2", BUS_W'(cfg_ready), BUS_W'(1));
        chk("a_cnt", BUS_W'(word_count), BUS_W'(3));
        idle(3);

        // Stream B: out-of-range word and duplicate address
        send(4, 1, 0);
        send(20, 7, 0);
        chk("b_err_mid", BUS_W'(err_addr), BUS_W'(1));
        chk("b_bus_mid", config_sig_bus, 64'h9000_0000_0000_5002);
        send(4, 6, 1);
        idle(4);
        chk("b_bus", config_sig_bus, 64'h9000_0000_0006_5002);
        chk("b_err", BUS_W'(err_addr), BUS_W'(1));
        chk("b_cnt", BUS_W'(word_count), BUS_W'(3));

        // Stream C: single word clears err at its transfer
        send(3, 8, 1);
        cfg_valid = 1'b0;
        chk("c_err_clr", BUS_W'(err_addr), BUS_W'(0));
        chk("c_cnt", BUS_W'(word_count), BUS_W'(1));
        idle(4);
        chk("c_bus", config_sig_bus, 64'h9000_0000_0006_8002);

        // Out-of-range last word still commits
        send(2, 10, 0);
        send(31, 1, 1);
        idle(4);
        chk("oor_last_bus", config_sig_bus, 64'h9000_0000_0006_8A02);
        chk("oor_last_err", BUS_W'(err_addr), BUS_W'(1));

        // Long stream to saturate the word counter
        for (int i = 0; i < 260; i++) send(7, i % 16, i == 259);
        idle(4);
        chk("sat_cnt", BUS_W'(word_count), BUS_W'(255));
        chk("sat_bus", config_sig_bus, 64'h9000_0000_3006_8A02);

        // Reset mid-load discards everything
        send(2, 3, 0);
        send(5, 7, 0);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_bus", config_sig_bus, '0);
        chk("rst_ready", BUS_W'(cfg_ready), BUS_W'(0));
        step();
        step();
        rst_n = 1'b1;
        send(1, 4, 1);
        cfg_valid = 1'b0;
        idle(4);
        chk("post_rst_bus", config_sig_bus, 64'h0000_0000_0000_0040);
        chk("post_rst_cnt", BUS_W'(word_count), BUS_W'(1));

        idle(3);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fu_cfg_loader.md
Name: fu_cfg_loader

Overview:
- Configuration source for the array's function cells. It drives the 4-bit config_sig inputs that the ALU cells consume.
- Accepts a stream of addressed configuration words over a valid/ready interface from the config bus and writes them into a shadow register bank.
- On the last word of a stream, it commits the whole shadow bank to the active bank atomically in one cycle.
- Because of the atomic commit, function cells never see a partially loaded configuration.

Parameters:
- NUM_FU, 16, number of function cells served; one config slot per cell.
- CFG_W, 4, config width per cell; matches the config_sig width of the ALU cells.
- ADDR_W, 5, width of the slot address; must satisfy 2^ADDR_W > NUM_FU so that out-of-range addresses are testable.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  config word present on cfg_addr/cfg_data/cfg_last.
- cfg_ready  output  1  loader can accept a word this cycle.
- cfg_addr  input  ADDR_W  target slot index.
- cfg_data  input  CFG_W  config value for the slot.
- cfg_last  input  1  marks the final word of a stream.
- config_sig_bus  output  NUM_FU*CFG_W  active configs; slot i occupies bits [i*CFG_W +: CFG_W].
- commit_done  output  1  one-cycle pulse after the active bank updates.
- err_addr  output  1  sticky flag: a word with cfg_addr >= NUM_FU was accepted during the current or most recent stream.
- word_count  output  CNT_W  number of words accepted in the current or most recent stream.

Behaviour:
- Reset is asynchronous on falling rst_n and is held while rst_n=0. On reset:
  - state=IDLE.
  - Shadow and active banks are all 0, so config_sig_bus=0.
  - cfg_ready=0 while in reset; cfg_ready=1 from the first clk edge after rst_n rises.
  - commit_done=0, err_addr=0, word_count=0.
- Handshake: a word transfers on a rising edge where cfg_valid=1 and cfg_ready=1.
  - cfg_ready does not depend combinationally on cfg_valid.
  - The sender holds addr/data/last stable while cfg_valid=1 and cfg_ready=0.
- FSM states: IDLE, LOAD, COMMIT, DONE.
- IDLE: cfg_ready=1.
  - On transfer, err_addr and word_count are cleared, then the word is processed as in LOAD, so word_count=1 after the edge.
  - Next state is LOAD, or COMMIT if cfg_last=1.
- LOAD: cfg_ready=1.
  - Each transfer with cfg_addr < NUM_FU writes cfg_data to shadow[cfg_addr].
  - Each transfer with cfg_addr >= NUM_FU writes nothing and sets err_addr.
  - word_count increments on every transfer and saturates at 2^CNT_W-1.
  - A transfer with cfg_last=1 moves the FSM to COMMIT.
- COMMIT: one cycle, cfg_ready=0. At the closing edge, the active bank is loaded from the shadow bank (all slots at once). Next state is DONE.
- DONE: one cycle, cfg_ready=0, commit_done=1. Next state is IDLE.
- Latency: if the last word is accepted at edge N, then:
  - config_sig_bus changes at edge N+1;
  - commit_done is high during cycle N+1..N+2;
  - cfg_ready returns to 1 after edge N+2.
- The shadow bank persists across streams. Slots not written by a stream keep their previous value and are re-committed unchanged.
- Duplicate address within a stream: the last write wins.
- Out-of-range last word: it writes nothing, sets err_addr, and the commit still occurs.
- config_sig_bus changes only at the COMMIT edge, never during LOAD.
- Reset in any state returns everything to the reset values. A partially loaded stream is discarded and the active bank reads 0.
- cfg_valid=0 in any state has no effect; LOAD may idle indefinitely.

Test Plan:
- Reset then idle → config_sig_bus=0, cfg_ready=1, commit_done never pulses.
- Stream (addr 0,data 2),(3,5),(15,9,last), cfg_valid held high:
  - cfg_ready drops for 2 cycles after the last transfer;
  - bus slot0=2, slot3=5, slot15=9, all others 0;
  - commit_done is a single pulse; word_count=3.
- Check bus during LOAD: after the first two words of a stream, config_sig_bus still equals the prior commit. It updates exactly one edge after the last word is accepted.
- Stream (4,1),(20,7),(4,6,last) with NUM_FU=16:
  - err_addr=1, slot4=6, no other slot changed;
  - the next stream starting with a valid word clears err_addr at its first transfer.
- Second stream (3,8,last) after the first scenario → slot3=8; slots 0 and 15 keep 2 and 9; word_count=1.
- rst_n pulsed low mid-LOAD after 2 words, then a single-word stream (1,4,last) → only slot1=4, all other slots 0.
